// File: rtl/uart_rx_byte.sv
// ----------------------------------------------------------------------------
// uart_rx_byte
//
// Serial UART receiver for 8N1 frames, LSB first. The asynchronous rx line is
// passed through a two-flop synchroniser. Each bit is sampled at the middle of
// its bit period. A correctly framed byte is presented on dato together with
// a single-cycle rx_flat strobe. A frame whose stop bit is sampled low raises
// a single-cycle frame_err strobe instead, and dato is left unchanged.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit period (legal range 8..65535)
//   CNT_W         width of the bit-period counter (2**CNT_W > CLKS_PER_BIT)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   rx         raw serial line, idle high, asynchronous to clk
//   dato       last correctly received byte (held between strobes)
//   rx_flat    one-cycle strobe: new valid byte on dato
//   frame_err  one-cycle strobe: stop bit sampled low
//   busy       high whenever the receiver is not idle
// ----------------------------------------------------------------------------
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dato,
    output logic       rx_flat,
    output logic       frame_err,
    output logic       busy
);

    // The start bit is checked half a bit period after the falling edge.
    // Every later sample is a full period after the previous one, so all
    // samples land near the middle of their bits.
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       dato_reg, dato_next;
    logic             rx_flat_reg, rx_flat_next;
    logic             frame_err_reg, frame_err_next;

    // Two-flop synchroniser. Both flops reset to 1 so that reset does not
    // look like a start edge while the line is idle.
    logic sync1_reg;
    logic rxs_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            rxs_reg   <= 1'b1;
        end else begin
            sync1_reg <= rx;
            rxs_reg   <= sync1_reg;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            dato_reg      <= '0;
            rx_flat_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            dato_reg      <= dato_next;
            rx_flat_reg   <= rx_flat_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Next-state logic. Both strobes default low, so each lasts one cycle.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        dato_next      = dato_reg;
        rx_flat_next   = 1'b0;
        frame_err_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (!rxs_reg) begin
                    state_next = ST_START;
                end
            end

            ST_START: begin
                if (cnt_reg == HALF_M1) begin
                    cnt_next = '0;
                    if (!rxs_reg) begin
                        state_next   = ST_DATA;
                        bit_idx_next = '0;
                    end else begin
                        // The line went high again before mid start bit.
                        // Treat this as a glitch and do not flag it.
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (cnt_reg == FULL_M1) begin
                    cnt_next     = '0;
                    shift_next   = {rxs_reg, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_STOP: begin
                // The receiver goes back to idle in the middle of the stop
                // bit. A start edge at the end of the stop bit is then
                // caught without losing any cycles.
                if (cnt_reg == FULL_M1) begin
                    cnt_next = '0;
                    if (rxs_reg) begin
                        dato_next    = shift_reg;
                        rx_flat_next = 1'b1;
                        state_next   = ST_IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = ST_BREAK;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_BREAK: begin
                // Wait here while the line is held low. A break condition
                // therefore reports a single frame_err and nothing more.
                cnt_next = '0;
                if (rxs_reg) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign dato      = dato_reg;
    assign rx_flat   = rx_flat_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
module tb_uart_rx_byte;

    localparam int N       = 16;
    localparam int H       = N / 2;
    // Nominal latency from the start-bit falling edge to rx_flat, with +/-1.
    localparam int LAT_NOM = 2 + H + 9 * N + 1;
    localparam int LAT_MIN = LAT_NOM - 1;
    localparam int LAT_MAX = LAT_NOM + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] dato;
    logic       rx_flat;
    logic       frame_err;
    logic       busy;

    uart_rx_byte #(.CLKS_PER_BIT(N), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .dato      (dato),
        .rx_flat   (rx_flat),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int good_cnt = 0;
    int err_cnt  = 0;

    // Each complete frame sent adds one expected event to this queue.
    typedef struct {
        bit         good;
        logic [7:0] b;
        int         fall;
    } ev_t;
    ev_t exp_q[$];
    logic [7:0] model_dato = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Compare process: every cycle out of reset, match the strobes against
    // the expected-event queue and check dato against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                model_dato = 8'h00;
            end else begin
                check("strobe_exclusive", {31'd0, rx_flat & frame_err}, 32'd0);
                if (rx_flat || frame_err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", {30'd0, rx_flat, frame_err}, 32'd0);
                    end else begin
                        ev_t e;
                        int lat;
                        e = exp_q.pop_front();
                        lat = cyc - e.fall;
                        check("strobe_kind", {31'd0, rx_flat}, {31'd0, e.good});
                        checks++;
                        if (lat < LAT_MIN || lat > LAT_MAX) begin
                            failures++;
                            $display("FAIL latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
                        end
                        if (e.good) model_dato = e.b;
                        if (rx_flat) good_cnt++;
                        if (frame_err) err_cnt++;
                    end
                end
                check("dato_model", {24'd0, dato}, {24'd0, model_dato});
            end
        end
    end

    // Sends one frame, starting at the current negedge. The task returns on
    // the negedge where the next start bit may begin, so consecutive calls
    // give back-to-back frames.
    task automatic send_frame(input logic [7:0] b, input int period, input bit stop_val);
        ev_t e;
        e.good = stop_val;
        e.b    = b;
        e.fall = cyc + 1;
        exp_q.push_back(e);
        rx = 1'b0;
        repeat (period) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (period) @(negedge clk);
        end
        rx = stop_val;
        repeat (period) @(negedge clk);
    endtask

    initial begin
        int base;
        logic [7:0] ab;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_dato", {24'd0, dato}, 32'h00);
        check("rst_rx_flat", {31'd0, rx_flat}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1. Single frame 0xA5
        send_frame(8'hA5, N, 1'b1);
        repeat (4) @(negedge clk);
        check("t1_dato", {24'd0, dato}, 32'hA5);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_good_cnt", good_cnt, 32'd1);

        // 2. Eight frames back to back
        base = good_cnt;
        for (int i = 1; i <= 8; i++) begin
            ab = 8'(i);
            send_frame(ab, N, 1'b1);
        end
        repeat (4) @(negedge clk);
        check("t2_pulses", good_cnt - base, 32'd8);
        check("t2_dato", {24'd0, dato}, 32'h08);
        check("t2_no_err", err_cnt, 32'd0);

        // 3. Five-cycle glitch on an idle line
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("t3_busy_in_glitch", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        check("t3_busy_after", {31'd0, busy}, 32'd0);
        check("t3_no_strobe", good_cnt + err_cnt, 32'd9);

        // 4. Stop bit low, then a good frame
        send_frame(8'h3C, N, 1'b0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_err_cnt", err_cnt, 32'd1);
        check("t4_dato_kept", {24'd0, dato}, 32'h08);
        check("t4_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h7E, N, 1'b1);
        repeat (4) @(negedge clk);
        check("t4_dato_next", {24'd0, dato}, 32'h7E);

        // 5. Reset in the middle of data bit 4 of 0xFF
        rx = 1'b0;
        repeat (N) @(negedge clk);
        rx = 1'b1;
        repeat (4 * N + H) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_dato", {24'd0, dato}, 32'h00);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (3 * N) @(negedge clk);
        check("t5_no_strobe", good_cnt, 32'd10);
        send_frame(8'h55, N, 1'b1);
        repeat (4) @(negedge clk);
        check("t5_dato", {24'd0, dato}, 32'h55);

        // 6. 0xC3 at bit periods 15 and 17
        send_frame(8'hC3, N - 1, 1'b1);
        repeat (20) @(negedge clk);
        check("t6_fast_dato", {24'd0, dato}, 32'hC3);
        check("t6_fast_cnt", good_cnt, 32'd12);
        send_frame(8'hC3, N + 1, 1'b1);
        repeat (20) @(negedge clk);
        check("t6_slow_cnt", good_cnt, 32'd13);
        check("t6_err_cnt", err_cnt, 32'd1);

        // Every expected event must have been seen.
        check("missing_events", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
